// File: rtl/glyph_pixel_streamer_pkg.sv
// Shared constants and FSM encoding for the glyph pixel streamer.
package glyph_pixel_streamer_pkg;

    localparam int RGB565_W   = 16;
    localparam int CELL_PX    = 8;
    localparam int CELL_PX_2X = 16;
    localparam int DISP_W_PX  = 96;
    localparam int DISP_H_PX  = 64;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WIN  = 2'd1,
        ST_PIX  = 2'd2
    } state_t;

endpackage

// File: rtl/glyph_pixel_streamer_font.sv
// 8x8 ASCII font ROM: 64-bit glyph, MSB = top-left, row-major, left to right.
// Unpopulated codes render blank.
module ascii_font_8x8 (
    input  logic [7:0]  ascii,
    output logic [63:0] glyph
);

    always_comb begin
        glyph = '0;
        case (ascii)
            8'h30:   glyph = 64'h7CC6_CEDE_F6E6_7C00;
            8'h31:   glyph = 64'h3070_3030_3030_FC00;
            8'h41:   glyph = 64'h3078_CCCC_FCCC_CC00;
            8'h42:   glyph = 64'hFC66_667C_6666_FC00;
            default: glyph = '0;
        endcase
    end

endmodule

// File: rtl/glyph_pixel_streamer.sv
// Character-cell glyph streamer: one window command then the glyph's pixel words.
// Optional GLYPH_SCALE2X_EN replicates each font pixel 2x2 (16x16 cells).
module glyph_pixel_streamer
    import glyph_pixel_streamer_pkg::*;
#(
    parameter int DISP_COLS = DISP_W_PX / CELL_PX,
    parameter int DISP_ROWS = DISP_H_PX / CELL_PX,
    parameter int COLOR_W   = RGB565_W
) (
    input  logic               i_CLK,
    input  logic               i_RST,
    input  logic               i_CHAR_VALID,
    output logic               o_CHAR_READY,
    input  logic [7:0]         i_ASCII,
    input  logic [3:0]         i_COL,
    input  logic [2:0]         i_ROW,
    input  logic [COLOR_W-1:0] i_FG,
    input  logic [COLOR_W-1:0] i_BG,
    output logic               o_WIN_VALID,
    input  logic               i_WIN_READY,
    output logic [6:0]         o_X0,
    output logic [6:0]         o_X1,
    output logic [5:0]         o_Y0,
    output logic [5:0]         o_Y1,
    output logic               o_PIX_VALID,
    input  logic               i_PIX_READY,
    output logic [COLOR_W-1:0] o_PIX_DATA,
    output logic               o_PIX_LAST,
    output logic               o_ERR
);

`ifdef GLYPH_SCALE2X_EN
    localparam int CELL     = CELL_PX_2X;
    localparam int CELL_DIV = 2;
    localparam int IDX_W    = 8;
`else
    localparam int CELL     = CELL_PX;
    localparam int CELL_DIV = 1;
    localparam int IDX_W    = 6;
`endif
    localparam int SHIFT              = $clog2(CELL);
    localparam logic [3:0] COL_LIM    = 4'(DISP_COLS / CELL_DIV);
    localparam logic [3:0] ROW_LIM    = 4'(DISP_ROWS / CELL_DIV);
    localparam logic [IDX_W-1:0] LAST_IDX = '1;

    state_t             state;
    logic [7:0]         ascii_q;
    logic [COLOR_W-1:0] fg_q;
    logic [COLOR_W-1:0] bg_q;
    logic [63:0]        glyph_q;
    logic [63:0]        rom_glyph;
    logic [IDX_W-1:0]   idx;
    logic               in_range;

    // Font bit for a beat index; in 2x mode bits [4] and [0] select the replica.
    function automatic logic pick(input logic [63:0] g, input logic [IDX_W-1:0] n);
`ifdef GLYPH_SCALE2X_EN
        return g[~{n[7:5], n[3:1]}];
`else
        return g[~n];
`endif
    endfunction

    ascii_font_8x8 u_font (
        .ascii (ascii_q),
        .glyph (rom_glyph)
    );

    assign in_range = (i_COL < COL_LIM) && ({1'b0, i_ROW} < ROW_LIM);

    always_ff @(posedge i_CLK) begin
        if (i_RST) begin
            state        <= ST_IDLE;
            o_CHAR_READY <= 1'b1;
            o_WIN_VALID  <= 1'b0;
            o_PIX_VALID  <= 1'b0;
            o_PIX_LAST   <= 1'b0;
            o_PIX_DATA   <= '0;
            o_ERR        <= 1'b0;
            o_X0         <= '0;
            o_X1         <= '0;
            o_Y0         <= '0;
            o_Y1         <= '0;
            ascii_q      <= '0;
            fg_q         <= '0;
            bg_q         <= '0;
            glyph_q      <= '0;
            idx          <= '0;
        end else begin
            o_ERR <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (i_CHAR_VALID && o_CHAR_READY) begin
                        ascii_q <= i_ASCII;
                        fg_q    <= i_FG;
                        bg_q    <= i_BG;
                        if (in_range) begin
                            o_X0         <= 7'(i_COL) << SHIFT;
                            o_X1         <= (7'(i_COL) << SHIFT) + 7'(CELL - 1);
                            o_Y0         <= 6'(i_ROW) << SHIFT;
                            o_Y1         <= (6'(i_ROW) << SHIFT) + 6'(CELL - 1);
                            o_CHAR_READY <= 1'b0;
                            o_WIN_VALID  <= 1'b1;
                            state        <= ST_WIN;
                        end else begin
                            o_ERR <= 1'b1;
                        end
                    end
                end
                ST_WIN: begin
                    // ascii_q is frozen here, so the ROM output is already the glyph.
                    glyph_q <= rom_glyph;
                    if (i_WIN_READY) begin
                        o_WIN_VALID <= 1'b0;
                        o_PIX_VALID <= 1'b1;
                        o_PIX_LAST  <= 1'b0;
                        o_PIX_DATA  <= pick(rom_glyph, '0) ? fg_q : bg_q;
                        idx         <= '0;
                        state       <= ST_PIX;
                    end
                end
                ST_PIX: begin
                    if (i_PIX_READY) begin
                        if (o_PIX_LAST) begin
                            o_PIX_VALID  <= 1'b0;
                            o_PIX_LAST   <= 1'b0;
                            o_CHAR_READY <= 1'b1;
                            state        <= ST_IDLE;
                        end else begin
                            idx        <= idx + 1'b1;
                            o_PIX_DATA <= pick(glyph_q, idx + 1'b1) ? fg_q : bg_q;
                            o_PIX_LAST <= (idx + 1'b1 == LAST_IDX);
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_glyph_pixel_streamer.sv
// Self-checking bench for glyph_pixel_streamer against a font/geometry reference model.
module tb_glyph_pixel_streamer;

`ifdef GLYPH_SCALE2X_EN
    localparam int CS       = 16;
    localparam int COLS_LIM = 6;
    localparam int ROWS_LIM = 4;
`else
    localparam int CS       = 8;
    localparam int COLS_LIM = 12;
    localparam int ROWS_LIM = 8;
`endif
    localparam int BEATS = CS * CS;

    logic        clk = 1'b0;
    logic        i_RST, i_CHAR_VALID, i_WIN_READY, i_PIX_READY;
    logic [7:0]  i_ASCII;
    logic [3:0]  i_COL;
    logic [2:0]  i_ROW;
    logic [15:0] i_FG, i_BG;
    logic        o_CHAR_READY, o_WIN_VALID, o_PIX_VALID, o_PIX_LAST, o_ERR;
    logic [6:0]  o_X0, o_X1;
    logic [5:0]  o_Y0, o_Y1;
    logic [15:0] o_PIX_DATA;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    glyph_pixel_streamer dut (
        .i_CLK        (clk),
        .i_RST        (i_RST),
        .i_CHAR_VALID (i_CHAR_VALID),
        .o_CHAR_READY (o_CHAR_READY),
        .i_ASCII      (i_ASCII),
        .i_COL        (i_COL),
        .i_ROW        (i_ROW),
        .i_FG         (i_FG),
        .i_BG         (i_BG),
        .o_WIN_VALID  (o_WIN_VALID),
        .i_WIN_READY  (i_WIN_READY),
        .o_X0         (o_X0),
        .o_X1         (o_X1),
        .o_Y0         (o_Y0),
        .o_Y1         (o_Y1),
        .o_PIX_VALID  (o_PIX_VALID),
        .i_PIX_READY  (i_PIX_READY),
        .o_PIX_DATA   (o_PIX_DATA),
        .o_PIX_LAST   (o_PIX_LAST),
        .o_ERR        (o_ERR)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Font rows, leftmost pixel in bit 7.
    function automatic logic [7:0] font_row(input logic [7:0] a, input int r);
        logic [7:0] rows [8];
        case (a)
            8'h30:   rows = '{8'h7C, 8'hC6, 8'hCE, 8'hDE, 8'hF6, 8'hE6, 8'h7C, 8'h00};
            8'h31:   rows = '{8'h30, 8'h70, 8'h30, 8'h30, 8'h30, 8'h30, 8'hFC, 8'h00};
            8'h41:   rows = '{8'h30, 8'h78, 8'hCC, 8'hCC, 8'hFC, 8'hCC, 8'hCC, 8'h00};
            8'h42:   rows = '{8'hFC, 8'h66, 8'h66, 8'h7C, 8'h66, 8'h66, 8'hFC, 8'h00};
            default: rows = '{default: 8'h00};
        endcase
        return rows[r];
    endfunction

    function automatic logic [15:0] exp_pix(input logic [7:0] a, input logic [15:0] fg,
                                            input logic [15:0] bg, input int n);
        int s, r, c;
        logic [7:0] rb;
        s  = CS / 8;
        r  = (n / CS) / s;
        c  = (n % CS) / s;
        rb = font_row(a, r);
        return rb[7 - c] ? fg : bg;
    endfunction

    // mode 0: ready always, 1: pattern 1,0,0,1, 2: random. abort_at>=0 stops before that beat.
    task automatic run_glyph(input logic [7:0] a, input logic [3:0] col, input logic [2:0] row,
                             input logic [15:0] fg, input logic [15:0] bg,
                             input int mode, input int win_stall, input int abort_at);
        int k, cyc, budget;
        logic rdy, prev_stall, prev_last;
        logic [15:0] prev_data;
        budget = BEATS * 4 + 20;
        @(negedge clk);
        check("char_ready_idle", 32'(o_CHAR_READY), 32'd1);
        i_CHAR_VALID = 1'b1;
        i_ASCII = a; i_COL = col; i_ROW = row; i_FG = fg; i_BG = bg;
        i_WIN_READY = 1'b0; i_PIX_READY = 1'b0;
        @(negedge clk);
        i_CHAR_VALID = 1'b0;
        i_ASCII = 8'($urandom); i_FG = 16'($urandom); i_BG = 16'($urandom);
        i_COL = 4'($urandom); i_ROW = 3'($urandom);
        check("win_valid", 32'(o_WIN_VALID), 32'd1);
        check("char_ready_busy", 32'(o_CHAR_READY), 32'd0);
        check("x0", 32'(o_X0), 32'(col) * CS);
        check("x1", 32'(o_X1), 32'(col) * CS + CS - 1);
        check("y0", 32'(o_Y0), 32'(row) * CS);
        check("y1", 32'(o_Y1), 32'(row) * CS + CS - 1);
        for (int s = 0; s < win_stall; s++) begin
            @(negedge clk);
            check("win_hold", 32'(o_WIN_VALID), 32'd1);
            check("x0_hold", 32'(o_X0), 32'(col) * CS);
            check("y1_hold", 32'(o_Y1), 32'(row) * CS + CS - 1);
            check("pix_early", 32'(o_PIX_VALID), 32'd0);
        end
        i_WIN_READY = 1'b1;
        @(negedge clk);
        i_WIN_READY = 1'b0;
        check("win_drop", 32'(o_WIN_VALID), 32'd0);
        k = 0; cyc = 0; prev_stall = 1'b0; prev_data = '0; prev_last = 1'b0;
        while (k < BEATS && cyc < budget) begin
            if (k == abort_at) break;
            cyc++;
            case (mode)
                0:       rdy = 1'b1;
                1:       rdy = ((cyc - 1) % 4 == 0) || ((cyc - 1) % 4 == 3);
                default: rdy = 1'($urandom_range(0, 1));
            endcase
            i_PIX_READY = rdy;
            check("pix_valid", 32'(o_PIX_VALID), 32'd1);
            check("char_ready_pix", 32'(o_CHAR_READY), 32'd0);
            if (prev_stall) begin
                check("stall_data", 32'(o_PIX_DATA), 32'(prev_data));
                check("stall_last", 32'(o_PIX_LAST), 32'(prev_last));
            end
            if (rdy) begin
                check("pix_data", 32'(o_PIX_DATA), 32'(exp_pix(a, fg, bg, k)));
                check("pix_last", 32'(o_PIX_LAST), 32'(k == BEATS - 1));
                k++;
            end
            prev_stall = !rdy; prev_data = o_PIX_DATA; prev_last = o_PIX_LAST;
            @(negedge clk);
        end
        i_PIX_READY = 1'b0;
        if (abort_at < 0) begin
            check("beat_count", 32'(k), 32'(BEATS));
            if (mode == 0) check("b2b_cycles", 32'(cyc), 32'(BEATS));
            check("pix_valid_end", 32'(o_PIX_VALID), 32'd0);
            check("char_ready_end", 32'(o_CHAR_READY), 32'd1);
        end
    endtask

    task automatic run_err(input logic [3:0] col, input logic [2:0] row);
        @(negedge clk);
        i_CHAR_VALID = 1'b1; i_ASCII = 8'h41; i_COL = col; i_ROW = row;
        @(negedge clk);
        i_CHAR_VALID = 1'b0;
        check("err_pulse", 32'(o_ERR), 32'd1);
        check("err_no_win", 32'(o_WIN_VALID), 32'd0);
        check("err_ready", 32'(o_CHAR_READY), 32'd1);
        @(negedge clk);
        check("err_single", 32'(o_ERR), 32'd0);
        check("err_no_win2", 32'(o_WIN_VALID), 32'd0);
    endtask

    task automatic check_reset_state(input string pfx);
        check({pfx, "_char_ready"}, 32'(o_CHAR_READY), 32'd1);
        check({pfx, "_win_valid"}, 32'(o_WIN_VALID), 32'd0);
        check({pfx, "_pix_valid"}, 32'(o_PIX_VALID), 32'd0);
        check({pfx, "_pix_last"}, 32'(o_PIX_LAST), 32'd0);
        check({pfx, "_pix_data"}, 32'(o_PIX_DATA), 32'd0);
        check({pfx, "_err"}, 32'(o_ERR), 32'd0);
        check({pfx, "_x0"}, 32'(o_X0), 32'd0);
        check({pfx, "_y1"}, 32'(o_Y1), 32'd0);
    endtask

    initial begin
        logic [7:0] chars [6];
        chars = '{8'h30, 8'h31, 8'h41, 8'h42, 8'h20, 8'h7E};
        i_RST = 1'b1; i_CHAR_VALID = 1'b0; i_WIN_READY = 1'b0; i_PIX_READY = 1'b0;
        i_ASCII = '0; i_COL = '0; i_ROW = '0; i_FG = '0; i_BG = '0;
        repeat (3) @(negedge clk);
        check_reset_state("rst");
        i_RST = 1'b0;

        run_glyph(8'h41, 4'd0, 3'd0, 16'hFFFF, 16'h0000, 0, 0, -1);
        run_glyph(8'h42, 4'(COLS_LIM - 1), 3'(ROWS_LIM - 1), 16'h1234, 16'hABCD, 0, 2, -1);
        run_glyph(8'h30, 4'd3, 3'd2, 16'hF800, 16'h07E0, 1, 0, -1);
        run_err(4'(COLS_LIM), 3'd0);
        run_err(4'd15, 3'd1);
        run_glyph(8'h41, 4'd5, 3'd3, 16'hFFFF, 16'h0000, 0, 0, -1);

        run_glyph(8'h41, 4'd1, 3'd1, 16'h5555, 16'hAAAA, 0, 0, 20);
        i_RST = 1'b1;
        @(negedge clk);
        check_reset_state("midrst");
        i_RST = 1'b0;
        run_glyph(8'h42, 4'd2, 3'd1, 16'h07FF, 16'h0010, 0, 0, -1);

        for (int i = 0; i < 6; i++) begin
            run_glyph(chars[$urandom_range(0, 5)], 4'($urandom_range(0, COLS_LIM - 1)),
                      3'($urandom_range(0, ROWS_LIM - 1)), 16'($urandom), 16'($urandom),
                      2, $urandom_range(0, 2), -1);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
